// File: rtl/ring_mul_reconstruct_pkg.sv
// Shared definitions for the ring divider / reconstructor pair: default width,
// pair-select codes and the reconstructor FSM state type.
package ring_mul_reconstruct_pkg;

  localparam int unsigned DefWidth = 8;

  localparam logic [1:0] SelAb = 2'b00;
  localparam logic [1:0] SelBc = 2'b01;
  localparam logic [1:0] SelCd = 2'b10;
  localparam logic [1:0] SelDa = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/ring_mul_reconstruct_if.sv
// Request/result bundle for the ring reconstructor.
interface ring_mul_reconstruct_if #(
  parameter int unsigned Width = 8
);
  logic             start;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic [Width-1:0] c;
  logic [Width-1:0] d;
  logic [1:0]       select;
  logic [Width-1:0] rem;
  logic             busy;
  logic             done;
  logic [Width-1:0] out;
  logic             error;

  modport master (
    output start, a, b, c, d, select, rem,
    input  busy, done, out, error
  );

  modport slave (
    input  start, a, b, c, d, select, rem,
    output busy, done, out, error
  );
endinterface

// File: rtl/ring_pair_mux.sv
// Maps the pair select onto (quotient, divisor); shared with the ring divider.
module ring_pair_mux
  import ring_mul_reconstruct_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic [1:0]       sel_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic [Width-1:0] dv_o
);

  // Select the operand pair around the ring.
  always_comb begin
    q_o  = a_i;
    dv_o = b_i;
    unique case (sel_i)
      SelAb: begin q_o = a_i; dv_o = b_i; end
      SelBc: begin q_o = b_i; dv_o = c_i; end
      SelCd: begin q_o = c_i; dv_o = d_i; end
      SelDa: begin q_o = d_i; dv_o = a_i; end
      default: begin q_o = a_i; dv_o = b_i; end
    endcase
  end

endmodule

// File: rtl/ring_mul_reconstruct.sv
// Rebuilds a dividend as Q*Dv + R with a shift-add multiplier. Fixed latency:
// Width iterating RUN edges plus one finishing RUN edge that enters DONE.
module ring_mul_reconstruct
  import ring_mul_reconstruct_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ring_mul_reconstruct_if.slave bus
);

  localparam int unsigned CntW = $clog2(Width) + 1;
  localparam int unsigned AccW = 2 * Width;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]  mq_q, mq_d;
  logic [Width-1:0]  dv_q, dv_d;
  logic [Width-1:0]  rem_q, rem_d;
  logic [Width-1:0]  out_q, out_d;
  logic              err_q, err_d;
  logic [Width-1:0]  q_mux, dv_mux;

  ring_pair_mux #(
    .Width(Width)
  ) u_pair_mux (
    .sel_i(bus.select),
    .a_i  (bus.a),
    .b_i  (bus.b),
    .c_i  (bus.c),
    .d_i  (bus.d),
    .q_o  (q_mux),
    .dv_o (dv_mux)
  );

  // Next-state: accept in IDLE/DONE, iterate in RUN, finish on the count-full edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    dv_d    = dv_q;
    rem_d   = rem_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          cnt_d   = '0;
          mq_d    = q_mux;
          dv_d    = dv_mux;
          rem_d   = bus.rem;
          mcand_d = {{Width{1'b0}}, dv_mux};
          acc_d   = {{Width{1'b0}}, bus.rem};
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (cnt_q == CntW'(Width)) begin
          state_d = StDone;
          out_d   = acc_q[Width-1:0];
          // The accumulator is wide enough that overflow shows up in the high half.
          err_d   = (dv_q == '0) | (rem_q >= dv_q) | (acc_q[AccW-1:Width] != '0);
        end else begin
          if (mq_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mq_d    = mq_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.out   = out_q;
  assign bus.error = err_q;

endmodule
